// File: rtl/program_sequencer_pkg.sv
// rtl/program_sequencer_pkg.sv - shared opcodes, state encoding and default widths
package seq_pkg;

  localparam int N_DEF     = 4;
  localparam int CNT_W_DEF = 8;

  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_RTN = 4'hD;
  localparam logic [3:0] OP_SKZ = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // 2'd3 is never entered; the FSM treats it as IDLE on the next edge
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  // Flow-control opcodes occupy 4'hC..4'hF, everything else belongs to the ICU
  function automatic logic is_flow_op(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// rtl/program_sequencer_if.sv - sequencer-to-core/ROM signal bundle
interface program_sequencer_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             run;
  logic             step;
  logic [3:0]       opcode;
  logic [3:0]       operand;
  logic             result;
  logic [N-1:0]     addr;
  logic             exec_en;
  logic             halted;
  logic [CNT_W-1:0] retired;

  // Sequencer side drives the ROM address and status
  modport master (
    input  run, step, opcode, operand, result,
    output addr, exec_en, halted, retired
  );

  // Core/ROM/control side
  modport slave (
    output run, step, opcode, operand, result,
    input  addr, exec_en, halted, retired
  );
endinterface

// File: rtl/program_sequencer_next_addr.sv
// rtl/program_sequencer_next_addr.sv - combinational next addr/ret_addr for one RUN decode
module seq_next_addr
  import seq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [3:0]   opcode,
  input  logic [3:0]   operand,
  input  logic         result,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] ret_addr,
  output logic [N-1:0] next_addr,
  output logic [N-1:0] next_ret_addr
);

  // All arithmetic is N bits wide, so wrap modulo 2^N falls out naturally
  always_comb begin
    next_ret_addr = ret_addr;
    next_addr     = addr + N'(1);
    case (opcode)
      OP_JMP: begin
        next_addr     = operand[N-1:0];
        next_ret_addr = addr + N'(1);
      end
      OP_RTN: next_addr = ret_addr;
      OP_SKZ: next_addr = result ? addr + N'(1) : addr + N'(2);
      OP_HLT: next_addr = addr;
      default: next_addr = addr + N'(1);
    endcase
  end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - run/step sequencer with flow-control decode and retire counter
module program_sequencer
  import seq_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  program_sequencer_if.master bus
);

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     addr_q, addr_d;
  logic [N-1:0]     ret_addr_q, ret_addr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             halted_q, halted_d;
  logic [N-1:0]     nxt_addr, nxt_ret_addr;
  logic             go;
  logic             exec_en;

  // run and step together still count as a single go
  assign go = bus.run | bus.step;

  seq_next_addr #(.N(N)) u_next_addr (
    .opcode        (bus.opcode),
    .operand       (bus.operand),
    .result        (bus.result),
    .addr          (addr_q),
    .ret_addr      (ret_addr_q),
    .next_addr     (nxt_addr),
    .next_ret_addr (nxt_ret_addr)
  );

  // FSM and datapath next-state; exec_en is decoded combinationally from state/opcode/go
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ret_addr_d = ret_addr_q;
    retired_d  = retired_q;
    halted_d   = halted_q;
    exec_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) state_d = RUN;
      end
      RUN: begin
        if (go) begin
          addr_d     = nxt_addr;
          ret_addr_d = nxt_ret_addr;
          if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + CNT_W'(1);
          if (bus.opcode == OP_HLT) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
          exec_en = !is_flow_op(bus.opcode);
        end
      end
      HALT: begin
        if (bus.step) begin
          addr_d   = addr_q + N'(1);
          halted_d = 1'b0;
          state_d  = RUN;
        end
      end
      default: begin
        state_d  = IDLE;
        halted_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      ret_addr_q <= '0;
      retired_q  <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ret_addr_q <= ret_addr_d;
      retired_q  <= retired_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.addr    = addr_q;
  assign bus.exec_en = exec_en;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - directed self-checking bench for program_sequencer
module tb_program_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] rom [16];
  int         checks;
  int         failures;

  program_sequencer_if #(.N(4), .CNT_W(8)) bus ();
  program_sequencer_if #(.N(4), .CNT_W(2)) bus_s ();

  program_sequencer #(.N(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  program_sequencer #(.N(4), .CNT_W(2)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  assign bus.opcode    = rom[bus.addr][7:4];
  assign bus.operand   = rom[bus.addr][3:0];
  assign bus_s.opcode  = 4'h0;
  assign bus_s.operand = 4'h0;
  assign bus_s.result  = 1'b0;
  assign bus_s.step    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    bus.run    = 1'b0;
    bus.step   = 1'b0;
    bus.result = 1'b0;
    bus_s.run  = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rom_clear();
    bus.run    = 1'b0;
    bus.step   = 1'b0;
    bus.result = 1'b0;
    bus_s.run  = 1'b0;
    rst = 1'b1;
    #2;

    // Test 1: straight-line execution and async reset
    rom[0] = 8'h10; rom[1] = 8'h50; rom[2] = 8'h80; rom[3] = 8'h00;
    rst = 1'b0;
    #1;
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_retired", 32'(bus.retired), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_exec", 32'(bus.exec_en), 0);
    do_reset();
    bus.run = 1'b1;
    #1;
    chk("t1_idle_exec", 32'(bus.exec_en), 0);
    tick();
    chk("t1_fetch_addr", 32'(bus.addr), 0);
    chk("t1_fetch_ret", 32'(bus.retired), 0);
    chk("t1_exec0", 32'(bus.exec_en), 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_addr", 32'(bus.addr), 32'(i));
      chk("t1_exec", 32'(bus.exec_en), 1);
      chk("t1_retired", 32'(bus.retired), 32'(i));
    end
    #2;
    rst = 1'b0;
    #1;
    chk("t1_abort_addr", 32'(bus.addr), 0);
    chk("t1_abort_ret", 32'(bus.retired), 0);
    chk("t1_abort_exec", 32'(bus.exec_en), 0);

    // Test 2: JMP and RTN
    rom_clear();
    rom[0] = 8'hC5; rom[5] = 8'hC2; rom[2] = 8'h30; rom[3] = 8'hD0; rom[6] = 8'hF0;
    do_reset();
    bus.run = 1'b1;
    tick();
    tick();
    chk("t2_at5", 32'(bus.addr), 5);
    chk("t2_jmp_exec", 32'(bus.exec_en), 0);
    tick();
    chk("t2_at2", 32'(bus.addr), 2);
    chk("t2_nop_exec", 32'(bus.exec_en), 1);
    tick();
    chk("t2_at3", 32'(bus.addr), 3);
    chk("t2_rtn_exec", 32'(bus.exec_en), 0);
    tick();
    chk("t2_ret6", 32'(bus.addr), 6);
    chk("t2_retired", 32'(bus.retired), 4);

    // Test 3: SKZ with wrap
    rom_clear();
    rom[0] = 8'hCE; rom[14] = 8'hE0; rom[15] = 8'hE0;
    do_reset();
    bus.run = 1'b1;
    tick();
    tick();
    chk("t3_at14", 32'(bus.addr), 14);
    tick();
    chk("t3_skz14_r0", 32'(bus.addr), 0);
    tick();
    chk("t3_at14b", 32'(bus.addr), 14);
    bus.result = 1'b1;
    tick();
    chk("t3_skz14_r1", 32'(bus.addr), 15);
    bus.result = 1'b0;
    tick();
    chk("t3_skz15_r0", 32'(bus.addr), 1);

    // Test 4: HLT, run ignored, step resumes
    rom_clear();
    rom[4] = 8'hF0;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_at4", 32'(bus.addr), 4);
    chk("t4_hlt_exec", 32'(bus.exec_en), 0);
    tick();
    chk("t4_halted", 32'(bus.halted), 1);
    chk("t4_ret_hlt", 32'(bus.retired), 5);
    for (int i = 0; i < 10; i++) tick();
    chk("t4_hold_addr", 32'(bus.addr), 4);
    chk("t4_hold_ret", 32'(bus.retired), 5);
    chk("t4_hold_exec", 32'(bus.exec_en), 0);
    bus.run  = 1'b0;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    #1;
    chk("t4_step_addr", 32'(bus.addr), 5);
    chk("t4_step_halt", 32'(bus.halted), 0);
    chk("t4_step_ret", 32'(bus.retired), 5);
    tick();
    chk("t4_stall_addr", 32'(bus.addr), 5);
    bus.step = 1'b1;
    #1;
    chk("t4_run_exec", 32'(bus.exec_en), 1);
    tick();
    bus.step = 1'b0;
    chk("t4_run_addr", 32'(bus.addr), 6);
    chk("t4_run_ret", 32'(bus.retired), 6);

    // Test 5: single-stepping
    rom_clear();
    do_reset();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    chk("t5_fetch", 32'(bus.addr), 0);
    tick(); tick();
    chk("t5_stall_exec", 32'(bus.exec_en), 0);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick(); tick(); tick();
    chk("t5_step1", 32'(bus.addr), 1);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick(); tick();
    chk("t5_step2", 32'(bus.addr), 2);
    bus.run  = 1'b1;
    bus.step = 1'b1;
    tick();
    bus.run  = 1'b0;
    bus.step = 1'b0;
    tick();
    chk("t5_both_addr", 32'(bus.addr), 3);
    chk("t5_both_ret", 32'(bus.retired), 3);

    // Test 6: saturating counter on narrow instance
    do_reset();
    bus_s.run = 1'b1;
    tick();
    chk("t6_fetch", 32'(bus_s.retired), 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("t6_sat", 32'(bus_s.retired), (i > 3) ? 32'd3 : 32'(i));
    end
    chk("t6_addr", 32'(bus_s.addr), 5);
    bus_s.run = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
